// File: rtl/bus_checker_if.sv
// Single-direction data bus carrying a counter stream; width travels with the instance.
// Modport i is the receiving side, o the driving side.
interface bus #(
   parameter int DW = 8
);
   logic [DW-1:0] dat;

   modport i (input dat);
   modport o (output dat);
endinterface

// File: rtl/bus_checker.sv
// Locks onto an incrementing counter stream, then flags, counts and resyncs on mismatches.
// One-cycle latency from sample to every output; samples every cycle, no backpressure.
module bus_checker #(
   parameter int LOCK_N = 4,
   parameter int MISS_N = 2,
   parameter int ERR_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   bus.i                           i,
   input  logic                    clr,
   output logic                    locked,
   output logic                    err,
   output logic [ERR_W-1:0]        err_cnt,
   output logic [$bits(i.dat)-1:0] exp
);

   localparam int DW = $bits(i.dat);
   localparam logic [DW-1:0] ONE    = DW'(1);
   localparam logic [7:0]    LOCK_C = LOCK_N[7:0];
   localparam logic [7:0]    MISS_C = MISS_N[7:0];

   typedef enum logic {UNLOCK = 1'b0, LOCK = 1'b1} state_t;

   state_t           state_q;
   logic [DW-1:0]    prev_q;
   logic             prev_vld_q;
   logic [7:0]       run_q;
   logic [7:0]       miss_q;
   logic             locked_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic [DW-1:0]    exp_q;

   logic [DW-1:0]    exp_d;
   logic [DW-1:0]    prev_inc;
   logic [7:0]       run_inc;
   logic [7:0]       miss_inc;

   assign exp_d    = i.dat + ONE;
   assign prev_inc = prev_q + ONE;
   assign run_inc  = run_q + 8'd1;
   assign miss_inc = miss_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UNLOCK;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         run_q      <= '0;
         miss_q     <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         exp_q      <= '0;
      end else begin
         // Every sample becomes the new reference, so exp is always last sample + 1.
         prev_q     <= i.dat;
         prev_vld_q <= 1'b1;
         exp_q      <= exp_d;
         err_q      <= 1'b0;
         if (clr) begin
            err_cnt_q <= '0;
         end
         case (state_q)
            UNLOCK: begin
               if (prev_vld_q && (i.dat == prev_inc)) begin
                  if (run_inc == LOCK_C) begin
                     state_q  <= LOCK;
                     locked_q <= 1'b1;
                     run_q    <= '0;
                     miss_q   <= '0;
                  end else begin
                     run_q <= run_inc;
                  end
               end else begin
                  run_q <= '0;
               end
            end
            LOCK: begin
               if (i.dat == exp_q) begin
                  miss_q <= '0;
               end else begin
                  err_q <= 1'b1;
                  // A mismatch coinciding with clr is the first count after the clear.
                  if (clr) begin
                     err_cnt_q <= ERR_W'(1);
                  end else if (!(&err_cnt_q)) begin
                     err_cnt_q <= err_cnt_q + ERR_W'(1);
                  end
                  if (miss_inc == MISS_C) begin
                     state_q  <= UNLOCK;
                     locked_q <= 1'b0;
                     miss_q   <= '0;
                     run_q    <= '0;
                  end else begin
                     miss_q <= miss_inc;
                  end
               end
            end
            default: state_q <= UNLOCK;
         endcase
      end
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign exp     = exp_q;

endmodule

// File: tb/tb_bus_checker.sv
// Directed plus random stimulus for bus_checker, checked against a behavioural model.
module tb_bus_checker;
   localparam int DW      = 4;
   localparam int LOCK_N  = 4;
   localparam int MISS_N  = 2;
   localparam int ERR_W   = 2;
   localparam int MODV    = 1 << DW;
   localparam int CNT_MAX = (1 << ERR_W) - 1;

   logic             clk;
   logic             rst;
   logic             clr;
   logic             locked;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic [DW-1:0]    exp_w;

   bus #(.DW(DW)) b ();

   bus_checker #(
      .LOCK_N(LOCK_N),
      .MISS_N(MISS_N),
      .ERR_W (ERR_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .i      (b),
      .clr    (clr),
      .locked (locked),
      .err    (err),
      .err_cnt(err_cnt),
      .exp    (exp_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integers following the stream rules directly.
   bit m_lock;
   bit m_err;
   bit m_have_prev;
   int m_prev;
   int m_run;
   int m_miss;
   int m_cnt;
   int m_exp;

   task automatic m_reset();
      m_lock = 0; m_err = 0; m_have_prev = 0;
      m_prev = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_exp = 0;
   endtask

   task automatic m_sample(input int d, input bit c);
      bit counted;
      counted = 0;
      m_err   = 0;
      if (!m_lock) begin
         if (m_have_prev && d == (m_prev + 1) % MODV) begin
            m_run = m_run + 1;
            if (m_run == LOCK_N) begin
               m_lock = 1; m_run = 0; m_miss = 0;
            end
         end else begin
            m_run = 0;
         end
      end else if (d == m_exp) begin
         m_miss = 0;
      end else begin
         counted = 1;
         m_err   = 1;
         m_miss  = m_miss + 1;
         if (m_miss == MISS_N) begin
            m_lock = 0; m_run = 0; m_miss = 0;
         end
      end
      if (c) m_cnt = counted ? 1 : 0;
      else if (counted && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_prev = d;
      m_have_prev = 1;
      m_exp = (d + 1) % MODV;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".locked"}, {31'd0, locked}, m_lock);
      chk({tag, ".err"}, {31'd0, err}, m_err);
      chk({tag, ".err_cnt"}, {30'd0, err_cnt}, m_cnt);
      chk({tag, ".exp"}, {28'd0, exp_w}, m_exp);
   endtask

   task automatic step(input int d, input bit c);
      @(negedge clk);
      b.dat = DW'(d);
      clr   = c;
      @(posedge clk);
      m_sample(d, c);
      #1;
      chk_all("step");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      m_reset();
      #1;
      chk_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lock_from_zero();
      for (int k = 0; k <= 4; k++) step(k, 1'b0);
   endtask

   initial begin
      int d;
      bit c;
      rst   = 1'b1;
      clr   = 1'b0;
      b.dat = '0;
      m_reset();
      #1;
      chk_all("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Initial lock on 0..4
      lock_from_zero();
      chk("r031.locked", {31'd0, locked}, 1);
      chk("r031.exp", {28'd0, exp_w}, 5);

      // Single mismatch, then resync
      step(5, 0); step(6, 0); step(9, 0);
      chk("r033.err", {31'd0, err}, 1);
      chk("r033.cnt", {30'd0, err_cnt}, 1);
      step(10, 0);
      chk("r033.locked", {31'd0, locked}, 1);

      // Two mismatches drop lock
      do_reset();
      lock_from_zero();
      step(5, 0); step(6, 0); step(9, 0); step(3, 0);
      chk("r034.err", {31'd0, err}, 1);
      chk("r034.cnt", {30'd0, err_cnt}, 2);
      chk("r034.locked", {31'd0, locked}, 0);

      // Relock near the top, then wrap through zero
      for (int k = 9; k <= 13; k++) step(k, 0);
      chk("relock.locked", {31'd0, locked}, 1);
      step(14, 0); step(15, 0); step(0, 0); step(1, 0);
      chk("r032.exp", {28'd0, exp_w}, 2);
      chk("r032.cnt", {30'd0, err_cnt}, 2);
      chk("r032.locked", {31'd0, locked}, 1);

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      chk("r036.locked", {31'd0, locked}, 0);
      chk("r036.cnt", {30'd0, err_cnt}, 0);
      chk_all("r036");
      @(negedge clk);
      rst = 1'b0;
      lock_from_zero();
      chk("r036.relock", {31'd0, locked}, 1);

      // Isolated mismatches saturate the counter
      for (int k = 0; k < 5; k++) begin
         step((m_exp + 3) % MODV, 0);
         step((m_prev + 1) % MODV, 0);
      end
      chk("r035.sat", {30'd0, err_cnt}, 3);
      step((m_exp + 7) % MODV, 1);
      chk("r035.clr_miss", {30'd0, err_cnt}, 1);
      step((m_prev + 1) % MODV, 1);
      chk("clr_alone", {30'd0, err_cnt}, 0);
      chk("clr_locked", {31'd0, locked}, 1);

      // Random mostly-in-sequence traffic
      for (int n = 0; n < 400; n++) begin
         d = ($urandom_range(0, 9) < 8) ? (m_prev + 1) % MODV : int'($urandom_range(0, MODV - 1));
         c = ($urandom_range(0, 19) == 0);
         step(d, c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
